// File: rtl/argmax_unit.sv
// argmax_unit: picks the winning class from a serial logit stream.
// Reports index, best logit, best-minus-runner-up margin and length error.
module argmax_unit #(
  parameter int LOGIT_W     = 32,
  parameter int NUM_CLASSES = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [LOGIT_W-1:0] in_data,
  input  logic                      in_last,
  output logic                      done,
  output logic [3:0]                predicted_digit,
  output logic signed [LOGIT_W-1:0] max_logit,
  output logic [LOGIT_W:0]          margin,
  output logic                      len_err
);

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  localparam logic [4:0] NC = 5'(NUM_CLASSES);

  state_t                    state_q, state_d;
  logic [3:0]                idx_q, idx_d;
  logic signed [LOGIT_W-1:0] best_q, best_d;
  logic signed [LOGIT_W-1:0] second_q, second_d;
  logic [3:0]                bidx_q, bidx_d;
  logic                      svld_q, svld_d;
  logic [3:0]                pred_q, pred_d;
  logic signed [LOGIT_W-1:0] max_q, max_d;
  logic [LOGIT_W:0]          margin_q, margin_d;
  logic                      err_q, err_d;

  logic                      accept;
  logic [4:0]                cnt;
  logic signed [LOGIT_W-1:0] nb, ns;
  logic [3:0]                nbi;
  logic                      nsv;
  logic [LOGIT_W:0]          diff;

  // Reset overrides the handshake so nothing is taken while rst is high.
  assign in_ready = (state_q == ACCUM) && !rst;
  assign accept   = in_valid && in_ready;
  assign done     = (state_q == REPORT);

  assign predicted_digit = pred_q;
  assign max_logit       = max_q;
  assign margin          = margin_q;
  assign len_err         = err_q;

  // Candidate tracker values if the current beat were accepted.
  always_comb begin
    nb   = best_q;
    nbi  = bidx_q;
    ns   = second_q;
    nsv  = svld_q;
    cnt  = {1'b0, idx_q} + 5'd1;
    if ({1'b0, idx_q} < NC) begin
      if (idx_q == 4'd0) begin
        nb  = in_data;
        nbi = idx_q;
        nsv = 1'b0;
      end else if (in_data > best_q) begin
        ns  = best_q;
        nsv = 1'b1;
        nb  = in_data;
        nbi = idx_q;
      end else if (!svld_q || in_data > second_q) begin
        ns  = in_data;
        nsv = 1'b1;
      end
    end
    diff = {nb[LOGIT_W-1], nb} - {ns[LOGIT_W-1], ns};
  end

  // Next-state, tracker and result register updates.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    best_d   = best_q;
    second_d = second_q;
    bidx_d   = bidx_q;
    svld_d   = svld_q;
    pred_d   = pred_q;
    max_d    = max_q;
    margin_d = margin_q;
    err_d    = err_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          best_d   = nb;
          bidx_d   = nbi;
          second_d = ns;
          svld_d   = nsv;
          idx_d    = (idx_q == 4'd15) ? idx_q : idx_q + 4'd1;
          if (in_last) begin
            state_d  = REPORT;
            pred_d   = nbi;
            max_d    = nb;
            margin_d = nsv ? diff : '0;
            err_d    = (cnt != NC);
            idx_d    = 4'd0;
            svld_d   = 1'b0;
          end
        end
      end
      REPORT: state_d = ACCUM;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACCUM;
      idx_q    <= '0;
      best_q   <= '0;
      second_q <= '0;
      bidx_q   <= '0;
      svld_q   <= 1'b0;
      pred_q   <= '0;
      max_q    <= '0;
      margin_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      best_q   <= best_d;
      second_q <= second_d;
      bidx_q   <= bidx_d;
      svld_q   <= svld_d;
      pred_q   <= pred_d;
      max_q    <= max_d;
      margin_q <= margin_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_argmax_unit.sv
// tb_argmax_unit: directed bench for argmax_unit.
// Each test task drives frames and compares against hand-computed results.
module tb_argmax_unit;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               in_last;
  logic               done;
  logic [3:0]         predicted_digit;
  logic signed [31:0] max_logit;
  logic [32:0]        margin;
  logic               len_err;

  int n_checks = 0;
  int n_fail   = 0;
  int fr[$];

  argmax_unit #(.LOGIT_W(32), .NUM_CLASSES(10)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .done(done),
    .predicted_digit(predicted_digit),
    .max_logit(max_logit),
    .margin(margin),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  // Drives fr[] as one frame; returns in the cycle after the last accept.
  task automatic send_frame(input bit gaps, input bit use_last,
                            output bit early_done, output bit timeout);
    int k;
    int cyc;
    bit acc;
    k = 0;
    cyc = 0;
    early_done = 1'b0;
    timeout = 1'b0;
    while (k < fr.size() && !timeout) begin
      in_valid = (gaps && k > 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = fr[k];
      in_last  = use_last && (k == fr.size() - 1);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      if (done && k < fr.size()) early_done = 1'b1;
      cyc++;
      if (cyc > 400) timeout = 1'b1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({done, in_ready, predicted_digit, max_logit, margin, len_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals: done=%0b rdy=%0b pred=%0d max=%0d mrg=%0d err=%0b, need all 0",
               done, in_ready, predicted_digit, max_logit, margin, len_err);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%0b done=%0b, need 1 0", in_ready, done);
    end
  endtask

  task automatic test_basic();
    bit ed, to;
    fr = '{5, -3, 12, 7, 0, -20, 11, 2, 1, -1};
    send_frame(1'b0, 1'b1, ed, to);
    n_checks++;
    if (to || ed || done !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hs: done=%0b rdy=%0b early=%0b to=%0b, need 1 0 0 0",
               done, in_ready, ed, to);
    end
    n_checks++;
    if (predicted_digit !== 4'd2 || max_logit !== 32'sd12 ||
        margin !== 33'd1 || len_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_res: pred=%0d max=%0d mrg=%0d err=%0b, need 2 12 1 0",
               predicted_digit, max_logit, margin, len_err);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || in_ready !== 1'b1 || predicted_digit !== 4'd2) begin
      n_fail++;
      $display("FAIL basic_after: done=%0b rdy=%0b pred=%0d, need 0 1 2",
               done, in_ready, predicted_digit);
    end
  endtask

  task automatic test_ties_negative();
    bit ed, to;
    fr = '{-4, 9, 9, 9, 9, 9, 9, 9, 9, 9};
    send_frame(1'b0, 1'b1, ed, to);
    n_checks++;
    if (to || done !== 1'b1 || predicted_digit !== 4'd1 || max_logit !== 32'sd9 ||
        margin !== 33'd0 || len_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ties: done=%0b pred=%0d max=%0d mrg=%0d err=%0b, need 1 1 9 0 0",
               done, predicted_digit, max_logit, margin, len_err);
    end
    fr = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91};
    send_frame(1'b0, 1'b1, ed, to);
    n_checks++;
    if (to || done !== 1'b1 || predicted_digit !== 4'd9 || max_logit !== -32'sd91 ||
        margin !== 33'd1 || len_err !== 1'b0) begin
      n_fail++;
      $display("FAIL negative: done=%0b pred=%0d max=%0d mrg=%0d err=%0b, need 1 9 -91 1 0",
               done, predicted_digit, max_logit, margin, len_err);
    end
  endtask

  task automatic test_extreme();
    bit ed, to;
    fr = '{32'h7FFFFFFF, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(1'b0, 1'b1, ed, to);
    n_checks++;
    if (to || done !== 1'b1 || predicted_digit !== 4'd0 ||
        max_logit !== 32'sh7FFFFFFF || margin !== 33'h0_7FFF_FFFF || len_err !== 1'b0) begin
      n_fail++;
      $display("FAIL extreme10: pred=%0d max=%h mrg=%h err=%0b, need 0 7fffffff 07fffffff 0",
               predicted_digit, max_logit, margin, len_err);
    end
    fr = '{32'h7FFFFFFF, 32'h80000000};
    send_frame(1'b0, 1'b1, ed, to);
    n_checks++;
    if (to || done !== 1'b1 || predicted_digit !== 4'd0 ||
        max_logit !== 32'sh7FFFFFFF || margin !== 33'h0_FFFF_FFFF || len_err !== 1'b1) begin
      n_fail++;
      $display("FAIL extreme2: pred=%0d max=%h mrg=%h err=%0b, need 0 7fffffff 0ffffffff 1",
               predicted_digit, max_logit, margin, len_err);
    end
  endtask

  task automatic test_len_err();
    bit ed, to;
    fr = '{3, 8, 1, 8, 2, -5, 0};
    send_frame(1'b0, 1'b1, ed, to);
    n_checks++;
    if (to || done !== 1'b1 || predicted_digit !== 4'd1 || max_logit !== 32'sd8 ||
        margin !== 33'd0 || len_err !== 1'b1) begin
      n_fail++;
      $display("FAIL len7: pred=%0d max=%0d mrg=%0d err=%0b, need 1 8 0 1",
               predicted_digit, max_logit, margin, len_err);
    end
    fr = '{0, 2, 4, 6, 8, 10, 12, 14, 16, 18, 100, 200};
    send_frame(1'b0, 1'b1, ed, to);
    n_checks++;
    if (to || done !== 1'b1 || predicted_digit !== 4'd9 || max_logit !== 32'sd18 ||
        margin !== 33'd2 || len_err !== 1'b1) begin
      n_fail++;
      $display("FAIL len12: pred=%0d max=%0d mrg=%0d err=%0b, need 9 18 2 1",
               predicted_digit, max_logit, margin, len_err);
    end
    fr = '{-7};
    send_frame(1'b0, 1'b1, ed, to);
    n_checks++;
    if (to || done !== 1'b1 || predicted_digit !== 4'd0 || max_logit !== -32'sd7 ||
        margin !== 33'd0 || len_err !== 1'b1) begin
      n_fail++;
      $display("FAIL len1: pred=%0d max=%0d mrg=%0d err=%0b, need 0 -7 0 1",
               predicted_digit, max_logit, margin, len_err);
    end
    fr = '{1, 1, 1, 50, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    send_frame(1'b0, 1'b1, ed, to);
    n_checks++;
    if (to || done !== 1'b1 || predicted_digit !== 4'd3 || max_logit !== 32'sd50 ||
        margin !== 33'd49 || len_err !== 1'b1) begin
      n_fail++;
      $display("FAIL len17: pred=%0d max=%0d mrg=%0d err=%0b, need 3 50 49 1",
               predicted_digit, max_logit, margin, len_err);
    end
  endtask

  task automatic test_back_to_back();
    bit ed, to;
    fr = '{5, -3, 12, 7, 0, -20, 11, 2, 1, -1};
    send_frame(1'b1, 1'b1, ed, to);
    n_checks++;
    if (to || ed || done !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hs_a: done=%0b rdy=%0b early=%0b to=%0b, need 1 0 0 0",
               done, in_ready, ed, to);
    end
    n_checks++;
    if (predicted_digit !== 4'd2 || max_logit !== 32'sd12 ||
        margin !== 33'd1 || len_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_res_a: pred=%0d max=%0d mrg=%0d err=%0b, need 2 12 1 0",
               predicted_digit, max_logit, margin, len_err);
    end
    fr = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91};
    send_frame(1'b1, 1'b1, ed, to);
    n_checks++;
    if (to || ed || done !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hs_b: done=%0b rdy=%0b early=%0b to=%0b, need 1 0 0 0",
               done, in_ready, ed, to);
    end
    n_checks++;
    if (predicted_digit !== 4'd9 || max_logit !== -32'sd91 ||
        margin !== 33'd1 || len_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_res_b: pred=%0d max=%0d mrg=%0d err=%0b, need 9 -91 1 0",
               predicted_digit, max_logit, margin, len_err);
    end
  endtask

  task automatic test_reset_midframe();
    bit ed, to;
    @(posedge clk);
    #1;
    fr = '{5, -3, 12, 7, 0};
    send_frame(1'b0, 1'b0, ed, to);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (ed || {done, in_ready, predicted_digit, max_logit, margin, len_err} !== '0) begin
      n_fail++;
      $display("FAIL midrst_during: done=%0b rdy=%0b pred=%0d max=%0d mrg=%0d err=%0b, need all 0",
               done, in_ready, predicted_digit, max_logit, margin, len_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 ||
        {done, predicted_digit, max_logit, margin, len_err} !== '0) begin
      n_fail++;
      $display("FAIL midrst_after: done=%0b rdy=%0b pred=%0d max=%0d mrg=%0d err=%0b, need rdy 1 rest 0",
               done, in_ready, predicted_digit, max_logit, margin, len_err);
    end
    fr = '{5, -3, 12, 7, 0, -20, 11, 2, 1, -1};
    send_frame(1'b0, 1'b1, ed, to);
    n_checks++;
    if (to || ed || done !== 1'b1 || predicted_digit !== 4'd2 || max_logit !== 32'sd12 ||
        margin !== 33'd1 || len_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clean: done=%0b pred=%0d max=%0d mrg=%0d err=%0b, need 1 2 12 1 0",
               done, predicted_digit, max_logit, margin, len_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties_negative();
    test_extreme();
    test_len_err();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
